// File: rtl/fib_pkg.sv
// Shared types and helpers for the Fibonacci stream checker.
package fib_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FAIL = 2'd2
  } fib_chk_state_e;

  localparam int FIB_WIDTH    = 16;
  localparam int FIB_IDX_W    = 32;
  localparam int FIB_ERR_W    = 16;
  localparam int FIB_LOCK_CNT = 3;

  // Increment that sticks at limit instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input logic [31:0] limit);
    return (value >= limit) ? limit : value + 32'd1;
  endfunction

endpackage

// File: rtl/fib_resync_window.sv
// Candidate window for re-acquiring the Fibonacci sequence after a failure.
// Holds the last two accepted samples and flags a sample that continues them.
// Only compiled in builds with FIB_CHK_RESYNC_EN defined.
`ifdef FIB_CHK_RESYNC_EN
module fib_resync_window import fib_pkg::*; #(
  parameter int WIDTH = FIB_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             shift,
  input  logic [WIDTH-1:0] sample,
  output logic             relock,
  output logic [WIDTH-1:0] cand_b
);

  logic [WIDTH-1:0] cand_a_q;
  logic [WIDTH-1:0] cand_b_q;
  logic             va_q;
  logic             vb_q;

  // Shift the newest sample in; clear empties both entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_a_q <= '0;
      cand_b_q <= '0;
      va_q     <= 1'b0;
      vb_q     <= 1'b0;
    end else if (clear) begin
      cand_a_q <= '0;
      cand_b_q <= '0;
      va_q     <= 1'b0;
      vb_q     <= 1'b0;
    end else if (shift) begin
      cand_a_q <= cand_b_q;
      cand_b_q <= sample;
      va_q     <= vb_q;
      vb_q     <= 1'b1;
    end
  end

  // A full window whose sum equals the incoming sample means we are back in step.
  always_comb begin
    relock = va_q && vb_q && (sample == WIDTH'(cand_a_q + cand_b_q));
  end

  assign cand_b = cand_b_q;

endmodule
`endif

// File: rtl/fib_seq_checker.sv
// Fibonacci stream checker: compares each accepted sample against
// F(0)=0, F(1)=1, F(n+2)=F(n)+F(n+1) mod 2^WIDTH and reports verdicts,
// lock status, a saturating error count and the first error index.
// Optional build macro FIB_CHK_RESYNC_EN: lets the FAIL state relock onto
// the stream once two accepted samples and their sum are seen in a row.
module fib_seq_checker import fib_pkg::*; #(
  parameter int WIDTH    = FIB_WIDTH,
  parameter int IDX_W    = FIB_IDX_W,
  parameter int ERR_W    = FIB_ERR_W,
  parameter int LOCK_CNT = FIB_LOCK_CNT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             chk_valid,
  output logic             chk_ok,
  output logic [IDX_W-1:0] chk_index,
  output logic             locked,
  output logic [ERR_W-1:0] err_cnt,
  output logic [IDX_W-1:0] first_err_index
);

  localparam int          RUN_W    = $clog2(LOCK_CNT + 1);
  localparam logic [31:0] LOCK_MAX = 32'(LOCK_CNT);
  localparam logic [31:0] ERR_MAX  = (ERR_W >= 32) ? 32'hFFFF_FFFF
                                                   : ((32'd1 << ERR_W) - 32'd1);

  fib_chk_state_e   state_q, state_d;
  logic [WIDTH-1:0] exp_a_q, exp_a_d;
  logic [WIDTH-1:0] exp_b_q, exp_b_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             locked_q, locked_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [IDX_W-1:0] first_q, first_d;
  logic             vld_p1, vld_d;
  logic             ok_p1, ok_d;
  logic [IDX_W-1:0] index_p1, index_d;

  logic             accept;
  logic             match;
  logic             enter_fail;
  logic [31:0]      run_inc;

  // start wins over a same-cycle sample.
  assign in_ready   = !start;
  assign accept     = in_valid && in_ready;
  assign match      = (in_data == exp_a_q);
  assign enter_fail = accept && (state_q == RUN) && !match;
  assign run_inc    = sat_inc(32'(run_q), LOCK_MAX);

`ifdef FIB_CHK_RESYNC_EN
  logic             relock;
  logic [WIDTH-1:0] cand_b;
  logic [WIDTH-1:0] relock_a;
  logic             win_clear;
  logic             win_shift;

  assign win_clear = start || enter_fail;
  assign win_shift = accept && (state_q == FAIL) && !relock;
  assign relock_a  = WIDTH'(cand_b + in_data);

  fib_resync_window #(.WIDTH(WIDTH)) u_resync_window (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (win_clear),
    .shift  (win_shift),
    .sample (in_data),
    .relock (relock),
    .cand_b (cand_b)
  );
`endif

  // Next-state, expectation update and verdict for the accepted sample.
  always_comb begin
    state_d  = state_q;
    exp_a_d  = exp_a_q;
    exp_b_d  = exp_b_q;
    idx_d    = idx_q;
    run_d    = run_q;
    locked_d = locked_q;
    err_d    = err_q;
    first_d  = first_q;
    vld_d    = 1'b0;
    ok_d     = ok_p1;
    index_d  = index_p1;

    if (start) begin
      state_d  = RUN;
      exp_a_d  = '0;
      exp_b_d  = WIDTH'(1);
      idx_d    = '0;
      run_d    = '0;
      locked_d = 1'b0;
    end else if (accept) begin
      case (state_q)
        RUN: begin
          vld_d   = 1'b1;
          ok_d    = match;
          index_d = idx_q;
          idx_d   = idx_q + 1'b1;
          if (match) begin
            exp_a_d  = exp_b_q;
            exp_b_d  = WIDTH'(exp_a_q + exp_b_q);
            run_d    = RUN_W'(run_inc);
            locked_d = (run_inc == LOCK_MAX);
          end else begin
            err_d    = ERR_W'(sat_inc(32'(err_q), ERR_MAX));
            if (err_q == '0) first_d = idx_q;
            locked_d = 1'b0;
            run_d    = '0;
            state_d  = FAIL;
          end
        end
        FAIL: begin
          vld_d   = 1'b1;
          ok_d    = 1'b0;
          index_d = idx_q;
          idx_d   = idx_q + 1'b1;
`ifdef FIB_CHK_RESYNC_EN
          // The relocking sample becomes index 0 of the re-acquired stream.
          if (relock) begin
            ok_d     = 1'b1;
            index_d  = '0;
            exp_a_d  = relock_a;
            exp_b_d  = WIDTH'(in_data + relock_a);
            idx_d    = IDX_W'(1);
            run_d    = RUN_W'(1);
            locked_d = (LOCK_MAX == 32'd1);
            state_d  = RUN;
          end
`endif
        end
        default: begin
          // IDLE drops samples without reporting them.
        end
      endcase
    end
  end

  // State and verdict registers; everything returns to zero on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      exp_a_q  <= '0;
      exp_b_q  <= WIDTH'(1);
      idx_q    <= '0;
      run_q    <= '0;
      locked_q <= 1'b0;
      err_q    <= '0;
      first_q  <= '0;
      vld_p1   <= 1'b0;
      ok_p1    <= 1'b0;
      index_p1 <= '0;
    end else begin
      state_q  <= state_d;
      exp_a_q  <= exp_a_d;
      exp_b_q  <= exp_b_d;
      idx_q    <= idx_d;
      run_q    <= run_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      first_q  <= first_d;
      vld_p1   <= vld_d;
      ok_p1    <= ok_d;
      index_p1 <= index_d;
    end
  end

  assign chk_valid       = vld_p1;
  assign chk_ok          = ok_p1;
  assign chk_index       = index_p1;
  assign locked          = locked_q;
  assign err_cnt         = err_q;
  assign first_err_index = first_q;

endmodule

// File: tb/tb_fib_seq_checker.sv
// Directed testbench for fib_seq_checker: a default-width instance and an
// 8-bit instance with a 2-bit error counter.
module tb_fib_seq_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;

  logic        start, in_valid;
  logic [15:0] in_data;
  logic        in_ready, chk_valid, chk_ok, locked;
  logic [31:0] chk_index, first_err_index;
  logic [15:0] err_cnt;

  logic        start8, valid8;
  logic [7:0]  data8;
  logic        ready8, cv8, ok8, lk8;
  logic [7:0]  idx8, fei8;
  logic [1:0]  err8;

  int tests = 0;
  int fails = 0;

  fib_seq_checker dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .chk_valid(chk_valid),
    .chk_ok(chk_ok), .chk_index(chk_index), .locked(locked),
    .err_cnt(err_cnt), .first_err_index(first_err_index)
  );

  fib_seq_checker #(.WIDTH(8), .IDX_W(8), .ERR_W(2), .LOCK_CNT(3)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .in_valid(valid8),
    .in_data(data8), .in_ready(ready8), .chk_valid(cv8),
    .chk_ok(ok8), .chk_index(idx8), .locked(lk8),
    .err_cnt(err8), .first_err_index(fei8)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic send(input logic [15:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send8(input logic [7:0] d);
    valid8 = 1'b1;
    data8  = d;
    @(posedge clk); #1;
    valid8 = 1'b0;
  endtask

  task automatic pulse_start8();
    start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
    start8 = 1'b0; valid8 = 1'b0; data8 = '0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({chk_valid, chk_ok, locked} !== 3'b000 || chk_index !== 32'd0 ||
        err_cnt !== 16'd0 || first_err_index !== 32'd0) begin
      fails++;
      $display("FAIL reset_outputs: valid=%0b ok=%0b locked=%0b idx=%0d err=%0d fei=%0d, want all 0",
               chk_valid, chk_ok, locked, chk_index, err_cnt, first_err_index);
    end
    tests++;
    if ({cv8, ok8, lk8} !== 3'b000 || idx8 !== 8'd0 || err8 !== 2'd0 || fei8 !== 8'd0) begin
      fails++;
      $display("FAIL reset_outputs8: valid=%0b ok=%0b locked=%0b idx=%0d err=%0d fei=%0d, want all 0",
               cv8, ok8, lk8, idx8, err8, fei8);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    // IDLE drops samples.
    send(16'd0);
    tests++;
    if (chk_valid !== 1'b0) begin
      fails++;
      $display("FAIL idle_drop: chk_valid=%0b, want 0", chk_valid);
    end
  endtask

  task automatic test_basic();
    logic [15:0] seq [7] = '{16'd0, 16'd1, 16'd1, 16'd2, 16'd3, 16'd5, 16'd8};
    pulse_start();
    for (int i = 0; i < 7; i++) begin
      send(seq[i]);
      tests++;
      if (chk_valid !== 1'b1 || chk_ok !== 1'b1 || chk_index !== 32'(i)) begin
        fails++;
        $display("FAIL basic_chk[%0d]: valid=%0b ok=%0b idx=%0d, want 1 1 %0d",
                 i, chk_valid, chk_ok, chk_index, i);
      end
      tests++;
      if (locked !== (i >= 2)) begin
        fails++;
        $display("FAIL basic_locked[%0d]: locked=%0b, want %0b", i, locked, (i >= 2));
      end
    end
    tests++;
    if (err_cnt !== 16'd0) begin
      fails++;
      $display("FAIL basic_err_cnt: err_cnt=%0d, want 0", err_cnt);
    end
    @(posedge clk); #1;
    tests++;
    if (chk_valid !== 1'b0) begin
      fails++;
      $display("FAIL basic_idle_valid: chk_valid=%0b, want 0", chk_valid);
    end
  endtask

  task automatic test_start_priority();
    start = 1'b1; in_valid = 1'b1; in_data = 16'd9;
    #1;
    tests++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL prio_ready: in_ready=%0b, want 0", in_ready);
    end
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b0;
    tests++;
    if (chk_valid !== 1'b0 || locked !== 1'b0) begin
      fails++;
      $display("FAIL prio_no_chk: chk_valid=%0b locked=%0b, want 0 0", chk_valid, locked);
    end
    send(16'd0);
    tests++;
    if (chk_valid !== 1'b1 || chk_ok !== 1'b1 || chk_index !== 32'd0) begin
      fails++;
      $display("FAIL prio_first: valid=%0b ok=%0b idx=%0d, want 1 1 0", chk_valid, chk_ok, chk_index);
    end
  endtask

  task automatic test_mismatch();
    logic [15:0] seq [6] = '{16'd0, 16'd1, 16'd1, 16'd2, 16'd4, 16'd7};
    logic        ok_e [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic        lk_e [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [15:0] er_e [6] = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd1, 16'd1};
    pulse_start();
    for (int i = 0; i < 6; i++) begin
      send(seq[i]);
      tests++;
      if (chk_valid !== 1'b1 || chk_ok !== ok_e[i] || chk_index !== 32'(i)) begin
        fails++;
        $display("FAIL mism_chk[%0d]: valid=%0b ok=%0b idx=%0d, want 1 %0b %0d",
                 i, chk_valid, chk_ok, chk_index, ok_e[i], i);
      end
      tests++;
      if (locked !== lk_e[i] || err_cnt !== er_e[i]) begin
        fails++;
        $display("FAIL mism_status[%0d]: locked=%0b err=%0d, want %0b %0d",
                 i, locked, err_cnt, lk_e[i], er_e[i]);
      end
    end
    tests++;
    if (first_err_index !== 32'd4) begin
      fails++;
      $display("FAIL mism_first_idx: first_err_index=%0d, want 4", first_err_index);
    end
  endtask

  task automatic test_resync();
    logic [15:0] seq [4] = '{16'd5, 16'd8, 16'd13, 16'd21};
`ifdef FIB_CHK_RESYNC_EN
    logic        ok_e [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] ix_e [4] = '{32'd6, 32'd7, 32'd0, 32'd1};
`else
    logic        ok_e [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
    logic [31:0] ix_e [4] = '{32'd6, 32'd7, 32'd8, 32'd9};
`endif
    for (int i = 0; i < 4; i++) begin
      send(seq[i]);
      tests++;
      if (chk_valid !== 1'b1 || chk_ok !== ok_e[i] || chk_index !== ix_e[i]) begin
        fails++;
        $display("FAIL resync_chk[%0d]: valid=%0b ok=%0b idx=%0d, want 1 %0b %0d",
                 i, chk_valid, chk_ok, chk_index, ok_e[i], ix_e[i]);
      end
    end
    tests++;
    if (err_cnt !== 16'd1) begin
      fails++;
      $display("FAIL resync_err_cnt: err_cnt=%0d, want 1", err_cnt);
    end
  endtask

  task automatic test_wrap8();
    logic [7:0] seq [15] = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13,
                             8'd21, 8'd34, 8'd55, 8'd89, 8'd144, 8'd233, 8'd121};
    pulse_start8();
    for (int i = 0; i < 15; i++) begin
      send8(seq[i]);
      tests++;
      if (cv8 !== 1'b1 || ok8 !== 1'b1 || idx8 !== 8'(i)) begin
        fails++;
        $display("FAIL wrap8_chk[%0d]: valid=%0b ok=%0b idx=%0d, want 1 1 %0d",
                 i, cv8, ok8, idx8, i);
      end
    end
  endtask

  task automatic test_sat_and_reset();
    pulse_start8();
    send8(8'd0);
    send8(8'd1);
    send8(8'd9);
    tests++;
    if (ok8 !== 1'b0 || err8 !== 2'd1 || fei8 !== 8'd2) begin
      fails++;
      $display("FAIL sat_run1: ok=%0b err=%0d fei=%0d, want 0 1 2", ok8, err8, fei8);
    end
    for (int r = 2; r <= 5; r++) begin
      pulse_start8();
      send8(8'd5);
      tests++;
      if (cv8 !== 1'b1 || ok8 !== 1'b0 || err8 !== 2'((r > 3) ? 3 : r) || fei8 !== 8'd2) begin
        fails++;
        $display("FAIL sat_run%0d: valid=%0b ok=%0b err=%0d fei=%0d, want 1 0 %0d 2",
                 r, cv8, ok8, err8, fei8, (r > 3) ? 3 : r);
      end
    end
    pulse_start8();
    send8(8'd0);
    send8(8'd1);
    rst_n = 1'b0;
    #1;
    tests++;
    if ({cv8, ok8, lk8} !== 3'b000 || idx8 !== 8'd0 || err8 !== 2'd0 || fei8 !== 8'd0) begin
      fails++;
      $display("FAIL async_reset8: valid=%0b ok=%0b locked=%0b idx=%0d err=%0d fei=%0d, want all 0",
               cv8, ok8, lk8, idx8, err8, fei8);
    end
    tests++;
    if ({chk_valid, chk_ok, locked} !== 3'b000 || chk_index !== 32'd0 ||
        err_cnt !== 16'd0 || first_err_index !== 32'd0) begin
      fails++;
      $display("FAIL async_reset: valid=%0b ok=%0b locked=%0b idx=%0d err=%0d fei=%0d, want all 0",
               chk_valid, chk_ok, locked, chk_index, err_cnt, first_err_index);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_start_priority();
    test_mismatch();
    test_resync();
    test_wrap8();
    test_sat_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fib_seq_checker.md
Name: fib_seq_checker

Overview:
- Receiver side of the Fibonacci stream. Consumes a valid-qualified stream of WIDTH-bit values and checks each sample against the expected sequence F(0)=0, F(1)=1, F(n+2)=F(n)+F(n+1), computed mod 2^WIDTH.
- Reports a per-sample verdict, lock status, a saturating error count and the index of the first error.
- Sits downstream of the sequence generator in self-test and loopback paths.

Parameters:
- WIDTH, 16, data width; sequence arithmetic is mod 2^WIDTH.
- IDX_W, 32, width of the sample index counter; wraps.
- ERR_W, 16, width of the error counter; saturates.
- LOCK_CNT, 3, consecutive matches required to assert locked (>=1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  single-cycle pulse; (re)arms the checker at F(0).
- in_valid  in  1  sample valid.
- in_data  in  WIDTH  sample value.
- in_ready  out  1  combinational, = !start; sample accepted when in_valid && in_ready.
- chk_valid  out  1  one-cycle pulse, one cycle after each checked sample.
- chk_ok  out  1  verdict, qualified by chk_valid.
- chk_index  out  IDX_W  index of the checked sample, qualified by chk_valid.
- locked  out  1  LOCK_CNT consecutive matches seen, no mismatch since.
- err_cnt  out  ERR_W  total mismatches since reset; saturating.
- first_err_index  out  IDX_W  chk_index of the first mismatch since reset.

Behaviour:
- Reset state:
  - All outputs 0; state IDLE.
  - exp_a=0, exp_b=1, idx=0, match_run=0.
- States: IDLE, RUN, FAIL.
- IDLE:
  - Accepted samples are dropped.
  - chk_valid stays 0.
- start (any state):
  - Next state RUN; exp_a=0, exp_b=1, idx=0, match_run=0, locked=0.
  - err_cnt and first_err_index are preserved.
  - start has priority: in_ready=0, so a same-cycle sample is not accepted.
- RUN, accepted sample:
  - Registered outputs next cycle: chk_valid=1, chk_ok=(in_data==exp_a), chk_index=idx.
  - idx advances by 1 and wraps.
- RUN, on match:
  - exp_a<=exp_b, exp_b<=exp_a+exp_b (carry discarded).
  - match_run increments, saturating at LOCK_CNT.
  - locked=1 from the cycle chk_valid reports the LOCK_CNT-th consecutive match.
- RUN, on mismatch:
  - err_cnt+1, saturating at 2^ERR_W-1.
  - If err_cnt was 0, first_err_index<=idx.
  - locked=0, match_run=0; next state FAIL. The expectation is not advanced.
- FAIL:
  - Accepted samples produce chk_valid=1, chk_ok=0, chk_index=idx; idx advances.
  - err_cnt is not incremented.
  - Exit only via start, or via resync (Optional Feature).
- Latency: exactly 1 cycle from acceptance to chk_valid. No back-to-back stalls; one sample per cycle is sustained.
- in_valid low: no state change; chk_valid=0.
- Async reset mid-stream: immediate return to the reset state, all outputs 0.

Optional Feature:
- Macro: FIB_CHK_RESYNC_EN.
- With the macro, in FAIL:
  - A two-entry window cand_a/cand_b holds the last two accepted samples.
  - Once both entries are full, a sample equal to cand_a+cand_b (mod 2^WIDTH) relocks: that sample reports chk_ok=1 with chk_index=0.
  - On relock: exp_a<=cand_b+sample, exp_b<=sample+exp_a_new, idx<=1, match_run=1, state RUN.
  - Otherwise the window shifts (cand_a<=cand_b, cand_b<=sample), and the sample reports chk_ok=0.
  - The window clears on start, reset, and entry to FAIL.
- Without the macro: FAIL is sticky until start. No window registers are present.

Decomposition:
- Package fib_pkg:
  - typedef enum fib_chk_state_e {IDLE, RUN, FAIL}.
  - Default WIDTH/IDX_W/ERR_W localparams.
  - Saturating-increment function.
- Sub-module fib_resync_window holds the candidate window and the relock compare. It is instantiated only under FIB_CHK_RESYNC_EN.

Test Plan:
1. start, then 0,1,1,2,3,5,8 back-to-back -> chk_ok=1 each, chk_index 0..6, locked rises with the 3rd chk_valid, err_cnt=0.
2. WIDTH=8: start, then F(0)..F(14) -> the 15th sample, 121 (377 mod 256), gives chk_ok=1 at chk_index=14.
3. start, then 0,1,1,2,4,7 -> chk_ok=0 at index 4, err_cnt=1, first_err_index=4, locked falls; index 5 also chk_ok=0, err_cnt stays 1.
4. start and in_valid with 9 in the same cycle -> in_ready=0, no chk_valid; next sample 0 -> chk_ok=1, chk_index=0.
5. FIB_CHK_RESYNC_EN: after test 3's FAIL, feed 5,8,13,21 -> 13 gives chk_ok=1, chk_index=0; 21 gives chk_ok=1, chk_index=1. Without the macro, all give chk_ok=0.
6. ERR_W=2: five start+bad-sample runs -> err_cnt saturates at 3, first_err_index from run 1. Assert rst_n mid-run -> all outputs 0 immediately.
